pc_fetch_seq: RTL

Fetch sequencer that drives the program counter's strobe interface (nrpc, nwpc, nincpc) from the initiating side, together with the address-register, memory-read and IR-latch strobes.
- Runs one instruction fetch per request: PC to ibus, into the address register, memory read, IR latch, then PC increment.
- Also performs jump loads (ibus into PC) on request.
- Sits on processor board B beside the PC and MAR and is controlled by the microcode sequencer.

---
 rtl/pc_fetch_seq_pkg.sv | 55 +++++
 rtl/pc_fetch_seq_if.sv | 28 ++
 rtl/pc_fetch_seq_strobe_reg.sv | 24 ++
 rtl/pc_fetch_seq.sv | 109 ++++++++++
 4 files changed

// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the PC fetch sequencer: state encoding, strobe-vector layout
// and the per-state strobe decode used to precompute the registered outputs.
package pc_fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        JUMP  = 3'd1,
        ADDR  = 3'd2,
        MEM   = 3'd3,
        LATCH = 3'd4,
        INC   = 3'd5,
        FAULT = 3'd6
    } state_e;

    localparam int STB_W      = 7;
    localparam int STB_NRPC   = 0;
    localparam int STB_NWPC   = 1;
    localparam int STB_NINCPC = 2;
    localparam int STB_NWAR   = 3;
    localparam int STB_NMEM   = 4;
    localparam int STB_NR     = 5;
    localparam int STB_NWIR   = 6;

    // Active-low strobe pattern driven while the sequencer sits in state s.
    function automatic logic [STB_W-1:0] strobesFor(input state_e s);
        logic [STB_W-1:0] v;
        v = '1;
        case (s)
            JUMP: begin
                v[STB_NWPC] = 1'b0;
            end
            ADDR: begin
                v[STB_NRPC] = 1'b0;
                v[STB_NWAR] = 1'b0;
            end
            MEM: begin
                v[STB_NMEM] = 1'b0;
                v[STB_NR]   = 1'b0;
            end
            LATCH: begin
                v[STB_NMEM] = 1'b0;
                v[STB_NR]   = 1'b0;
                v[STB_NWIR] = 1'b0;
            end
            INC: begin
                v[STB_NINCPC] = 1'b0;
            end
            default: begin
                v = '1;
            end
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Request/strobe bundle between the fetch sequencer (master) and the board side
// (slave: microcode sequencer requests, memory wait, PC/MAR/IR strobe receivers).
interface pc_fetch_seq_if;

    logic nfetch;
    logic njump;
    logic nwaiting;
    logic nrpc;
    logic nwpc;
    logic nincpc;
    logic nwar;
    logic nmem;
    logic nr;
    logic nwir;
    logic busy;
    logic fault;

    modport master (
        input  nfetch, njump, nwaiting,
        output nrpc, nwpc, nincpc, nwar, nmem, nr, nwir, busy, fault
    );

    modport slave (
        output nfetch, njump, nwaiting,
        input  nrpc, nwpc, nincpc, nwar, nmem, nr, nwir, busy, fault
    );

endinterface

// File: rtl/pc_fetch_seq_strobe_reg.sv
// Holds the active-low strobe vector; asynchronous preset to all-ones so every
// strobe is released the instant reset is asserted.
module strobe_reg
    import pc_fetch_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [STB_W-1:0] d_i,
    output logic [STB_W-1:0] q_o
);

    logic [STB_W-1:0] strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= '1;
        end else begin
            strobe_q <= d_i;
        end
    end

    assign q_o = strobe_q;

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: drives PC, MAR, memory-read and IR strobes for one fetch or jump
// per request. All pin outputs come straight from flops.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter int MEM_LAT  = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           nreset,
    pc_fetch_seq_if.master bus
);

    localparam logic [3:0] MEM_LAT_C  = 4'(MEM_LAT);
    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

    state_e           state_q, state_d;
    logic [3:0]       memCnt_q, memCnt_d;
    logic [7:0]       waitCnt_q, waitCnt_d;
    logic [7:0]       waitInc;
    logic             busy_q;
    logic             fault_q;
    logic [STB_W-1:0] strobe_d;
    logic [STB_W-1:0] strobe_q;

    // Next state and counters; the strobe vector is decoded from the next state so
    // the registered pins line up with the state they belong to.
    always_comb begin
        state_d   = state_q;
        memCnt_d  = memCnt_q;
        waitCnt_d = waitCnt_q;
        waitInc   = (waitCnt_q == 8'hFF) ? waitCnt_q : waitCnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                if (!bus.njump) begin
                    state_d = JUMP;
                end else if (!bus.nfetch) begin
                    state_d = ADDR;
                end
            end
            JUMP: begin
                state_d = IDLE;
            end
            ADDR: begin
                state_d   = MEM;
                memCnt_d  = 4'd1;
                waitCnt_d = 8'd0;
            end
            MEM: begin
                memCnt_d = (memCnt_q == 4'hF) ? memCnt_q : memCnt_q + 4'd1;
                if (!bus.nwaiting) begin
                    waitCnt_d = waitInc;
                    if (waitInc >= WAIT_MAX_C) begin
                        state_d = FAULT;
                    end
                end else if (memCnt_q >= MEM_LAT_C) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = INC;
            end
            INC: begin
                state_d = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        strobe_d = strobesFor(state_d);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            memCnt_q  <= 4'd0;
            waitCnt_q <= 8'd0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            memCnt_q  <= memCnt_d;
            waitCnt_q <= waitCnt_d;
            busy_q    <= (state_d != IDLE);
            fault_q   <= (state_d == FAULT);
        end
    end

    strobe_reg u_strobe_reg (
        .clk   (clk),
        .rst_n (nreset),
        .d_i   (strobe_d),
        .q_o   (strobe_q)
    );

    assign bus.nrpc   = strobe_q[STB_NRPC];
    assign bus.nwpc   = strobe_q[STB_NWPC];
    assign bus.nincpc = strobe_q[STB_NINCPC];
    assign bus.nwar   = strobe_q[STB_NWAR];
    assign bus.nmem   = strobe_q[STB_NMEM];
    assign bus.nr     = strobe_q[STB_NR];
    assign bus.nwir   = strobe_q[STB_NWIR];
    assign bus.busy   = busy_q;
    assign bus.fault  = fault_q;

endmodule
